// File: rtl/iir_inverse_filter.sv
// iir_inverse_filter: recovers x[n] = y[n] - (a*y[n-1])[3:0] with a 4-cycle shift-add multiply.
// Optional macro IIR_INV_COUNT_EN adds the sample_cnt output-handshake counter.
`default_nettype none

module iir_inverse_filter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       a,
    input  logic [3:0]       y_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       x_out,
    output logic             out_valid,
    input  logic             out_ready
`ifdef IIR_INV_COUNT_EN
    ,
    output logic [CNT_W-1:0] sample_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] y_q, y_d;
    logic [3:0] y_prev_q, y_prev_d;
    logic [7:0] acc_q, acc_d;
    logic [1:0] step_q, step_d;
    logic [3:0] x_q, x_d;
    logic       vld_q, vld_d;

    logic [7:0] a_ext;
    logic [7:0] pp;
    logic [7:0] acc_nxt;

    // Multiplier bits scan y_prev; the sign bit's partial product carries negative weight.
    assign a_ext   = {{4{a_q[3]}}, a_q};
    assign pp      = y_prev_q[step_q] ? (a_ext << step_q) : 8'd0;
    assign acc_nxt = (step_q == 2'd3) ? (acc_q - pp) : (acc_q + pp);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        y_d      = y_q;
        y_prev_d = y_prev_q;
        acc_d    = acc_q;
        step_d   = step_q;
        x_d      = x_q;
        vld_d    = vld_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    y_d     = y_in;
                    acc_d   = 8'd0;
                    step_d  = 2'd0;
                    state_d = S_MULT;
                end
            end
            S_MULT: begin
                acc_d  = acc_nxt;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    x_d     = y_q - acc_nxt[3:0];
                    vld_d   = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    vld_d    = 1'b0;
                    y_prev_d = y_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 4'd0;
            y_q      <= 4'd0;
            y_prev_q <= 4'd0;
            acc_q    <= 8'd0;
            step_q   <= 2'd0;
            x_q      <= 4'd0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            y_q      <= y_d;
            y_prev_q <= y_prev_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            x_q      <= x_d;
            vld_q    <= vld_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign x_out     = x_q;
    assign out_valid = vld_q;

`ifdef IIR_INV_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == S_OUT) && out_ready) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sample_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iir_inverse_filter.sv
// Self-checking bench for iir_inverse_filter: directed cases plus a random IIR chain model.
`default_nettype none

module tb_iir_inverse_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'd0;
    logic [3:0] y_in = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] x_out;
    logic       out_valid;
    logic       out_ready = 1'b0;
`ifdef IIR_INV_COUNT_EN
    logic [7:0] sample_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int yprev_m  = 0;
    int count_m  = 0;

    iir_inverse_filter #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef IIR_INV_COUNT_EN
        ,
        .sample_cnt(sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Send one sample, optionally stall the output for `stall` cycles, then hand it off.
    task automatic run_sample(input logic [3:0] av, input logic [3:0] yv,
                              input logic [3:0] xexp, input int stall, input string tag);
        int k;
        logic [3:0] held;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        a = av; y_in = yv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1; k++;
        end
        // Accepting edge plus four multiply edges: out_valid seen on the 4th edge after accept.
        check({tag, "_latency"}, k, 4);
        check({tag, "_x"}, x_out, xexp);
        check({tag, "_in_ready_out"}, in_ready, 0);
        held = x_out;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1; a = 4'($urandom); y_in = 4'($urandom);
            @(posedge clk); #1;
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_x"}, x_out, held);
            check({tag, "_stall_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_done_valid"}, out_valid, 0);
        check({tag, "_done_in_ready"}, in_ready, 1);
        yprev_m = yv;
        count_m++;
    endtask

    initial begin
        int xv, av, p, yv;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
`ifdef IIR_INV_COUNT_EN
        check("rst_sample_cnt", sample_cnt, 0);
`endif

        // Directed arithmetic cases
        run_sample(4'd2, 4'd3, 4'd3, 0, "a2_y3");
        run_sample(4'd2, 4'd7, 4'd1, 0, "a2_y7");
        run_sample(4'd0, 4'd3, 4'd3, 0, "prime_y3");
        run_sample(4'hF, 4'd5, 4'h8, 0, "neg_a");
        run_sample(4'd0, 4'd7, 4'd7, 0, "prime_y7");
        run_sample(4'd7, 4'd0, 4'hF, 0, "wrap");

        // Output stall with ignored in_valid pulses; y_prev must then be 4 exactly once
        run_sample(4'd0, 4'd4, 4'd4, 3, "stall");
        run_sample(4'd3, 4'd1, 4'(1 - 3 * 4), 0, "after_stall");

        // Reset during the second multiply cycle
        a = 4'd3; y_in = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x_out", x_out, 0);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_idle", in_ready, 1);
        yprev_m = 0;
        count_m = 0;
        run_sample(4'($urandom), 4'd9, 4'd9, 0, "after_rst");

        // Random chain through the forward IIR model y = x + (a*y_prev) mod 16
        for (int i = 0; i < 1000; i++) begin
            xv = int'($urandom_range(15, 0));
            av = int'($urandom_range(15, 0));
            p  = sx4(av) * sx4(yprev_m);
            yv = (xv + p) & 15;
            run_sample(4'(av), 4'(yv), 4'(xv), (i % 50 == 0) ? 2 : 0, "chain");
        end

`ifdef IIR_INV_COUNT_EN
        check("sample_cnt_wrap", sample_cnt, 32'(count_m % 256));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
